// File: rtl/fetch_redirect_unit.sv
// ============================================================================
// Module      : fetch_redirect_unit
// Description : Instruction-fetch stage and IF/ID pipeline register. Owns the
//               PC, drives a synchronous IMEM, redirects on jump/branch
//               flushes, holds on load-use stalls and counts flush/stall
//               cycles with saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IRFlush,
  input  logic        control_stall,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        hazard_stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_valid,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        do_flush;
  logic        do_stall;
  logic        load_bubble;
  logic        load_fetch;

  assign pc_plus4 = pc + 32'd4;

  // FSM state register: BOOT after reset, then RUN for good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // Next-state, next-PC and IF/ID control; the redirect outranks the stall,
  // and nothing is honoured during BOOT because imem_rdata is not yet valid.
  always_comb begin
    state_next  = RUN;
    do_flush    = 1'b0;
    do_stall    = 1'b0;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;
    pc_next     = pc_plus4;
    if (state == BOOT) begin
      pc_next     = pc;
      load_bubble = 1'b1;
    end else if (IRFlush) begin
      do_flush    = 1'b1;
      load_bubble = 1'b1;
      pc_next     = control_stall ? branch_target : jump_target;
    end else if (hazard_stall) begin
      do_stall = 1'b1;
      pc_next  = pc;
    end else begin
      load_fetch = 1'b1;
    end
  end

  // IMEM address is the next PC so the returning word always matches pc.
  assign imem_addr = pc_next;

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  // IF/ID register: bubble, capture, or hold (stall).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IF_ID_IR    <= NOP_WORD;
      IF_ID_PC4   <= 32'd0;
      IF_ID_valid <= 1'b0;
    end else if (load_bubble) begin
      IF_ID_IR    <= NOP_WORD;
      IF_ID_PC4   <= 32'd0;
      IF_ID_valid <= 1'b0;
    end else if (load_fetch) begin
      IF_ID_IR    <= imem_rdata;
      IF_ID_PC4   <= pc_plus4;
      IF_ID_valid <= 1'b1;
    end
  end

  // Saturating performance counters for redirect and stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (do_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 16'd1;
      if (do_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline, the consumer of the branch flush unit's `IRFlush` / `control_stall` pair. It does four things:
- owns the PC;
- drives a synchronous instruction memory;
- captures each fetched word plus PC+4 into IF/ID;
- on a flush, redirects to the jump or branch target and replaces the IF/ID contents with a bubble.

It also holds the PC and IF/ID for load-use stalls and counts flush and stall cycles for performance monitoring.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_WORD`, default 32'h0000_0000: instruction placed in IF/ID for a bubble (`sll $0,$0,0`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `IRFlush`  in  1  redirect request: jump in ID or taken branch in EX.
- `control_stall`  in  1  redirect source select: 1 selects `branch_target`, 0 selects `jump_target`. Meaningful only while `IRFlush`=1.
- `branch_target`  in  32  taken-branch target from EX.
- `jump_target`  in  32  jump target from ID.
- `hazard_stall`  in  1  load-use stall from the hazard detection unit.
- `imem_addr`  out  32  synchronous IMEM read address; data returns on `imem_rdata` the next cycle.
- `imem_rdata`  in  32  IMEM read data.
- `pc`  out  32  address of the instruction currently on `imem_rdata`.
- `IF_ID_IR`  out  32  IF/ID instruction.
- `IF_ID_PC4`  out  32  IF/ID PC+4.
- `IF_ID_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `flush_cnt`  out  16  saturating count of redirect cycles.
- `stall_cnt`  out  16  saturating count of hazard-stall cycles.

## Operation
- The FSM has two states, BOOT and RUN.
  - Reset forces BOOT.
  - BOOT lasts exactly one cycle after `rst` deasserts, then goes to RUN unconditionally.
  - In BOOT, `imem_rdata` is not yet valid for `pc`.
- The next PC is selected by these rules; the first matching rule wins:
  1. BOOT: `pc_next` = `pc`.
  2. `IRFlush`=1: `pc_next` = `control_stall` ? `branch_target` : `jump_target`.
  3. `hazard_stall`=1: `pc_next` = `pc`.
  4. Otherwise: `pc_next` = `pc` + 4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- `imem_addr` = `pc_next`, combinational. The IMEM word arriving next cycle therefore always corresponds to the new `pc`, and no extra bubble follows a redirect.
- `pc` <= `pc_next` every cycle.
- IF/ID update, same priority order:
  1. BOOT: load a bubble.
  2. `IRFlush`: load a bubble; the word on `imem_rdata` is wrong-path.
  3. `hazard_stall`: hold all three IF/ID fields.
  4. Otherwise: `IF_ID_IR` <= `imem_rdata`, `IF_ID_PC4` <= `pc`+4, `IF_ID_valid` <= 1.
- A bubble is `IF_ID_IR`=`NOP_WORD`, `IF_ID_PC4`=0, `IF_ID_valid`=0.
- `IRFlush` and `hazard_stall` asserted together: the redirect wins, the stall is ignored, and `stall_cnt` does not increment.
- Counters:
  - `flush_cnt` increments in each RUN cycle with `IRFlush`=1.
  - `stall_cnt` increments in each RUN cycle with `hazard_stall`=1 and `IRFlush`=0.
  - Both saturate at 16'hFFFF and never wrap.
- Inputs are ignored in BOOT: no redirect, no stall, no counting.
- Target alignment is not checked; low bits pass through unchanged.

## Timing
- Reset values, applied asynchronously on `rst` high:
  - `pc`=`RESET_PC`; `imem_addr`=`RESET_PC`.
  - `IF_ID_IR`=`NOP_WORD`, `IF_ID_PC4`=0, `IF_ID_valid`=0.
  - `flush_cnt`=0, `stall_cnt`=0; FSM in BOOT.
- Reset asserted mid-operation takes effect immediately, regardless of any in-progress flush or stall.
- Fetch latency: an address driven on `imem_addr` in cycle t is captured into IF/ID at the end of cycle t+1.
- First valid IF/ID entry: the instruction at `RESET_PC` appears with `IF_ID_valid`=1 after the 2nd rising edge following reset release.
- Redirect, `IRFlush` sampled high at edge e:
  - `pc` = target after e, and IF/ID is a bubble after e.
  - The target instruction is in IF/ID after e+1, provided no stall or flush occurs at e+1.
- Back-to-back `IRFlush` cycles: each one redirects and bubbles. The last one wins.
- A stall lasting N cycles holds `pc`, `imem_addr` and IF/ID constant for N cycles.
- All outputs except `imem_addr` are registered.

## Test plan
- **Reset and boot:** `RESET_PC`=0x100, `imem_rdata`=mem[addr]; release `rst`.
  - Cycle 1: `IF_ID_valid`=0.
  - Cycle 2: `IF_ID_IR`=mem[0x100], `IF_ID_PC4`=0x104, `pc`=0x104.
- **Jump redirect:** at `pc`=0x108, assert `IRFlush`=1, `control_stall`=0, `jump_target`=0x400 for one cycle.
  - Next edge: IF/ID is a bubble, `pc`=0x400, `flush_cnt`=1.
  - Edge after that: `IF_ID_IR`=mem[0x400], `IF_ID_PC4`=0x404.
- **Taken branch, select and simultaneity:** `IRFlush`=1, `control_stall`=1, `branch_target`=0x200, `jump_target`=0x400, `hazard_stall`=1.
  - Required: `pc`=0x200, IF/ID is a bubble, `stall_cnt` unchanged.
- **Load-use stall:** `hazard_stall`=1 for 3 cycles at `pc`=0x110.
  - During the stall: `pc`, `imem_addr` and IF/ID are frozen.
  - After the stall: `stall_cnt`=3; the next capture is mem[0x110] and sequential fetch resumes.
- **Saturation and wrap:**
  - Hold `IRFlush` high for 70000 cycles: `flush_cnt`=0xFFFF and stays there.
  - Separately, start at `pc`=0xFFFF_FFFC with no flush: `pc` wraps to 0x0.
- **Reset mid-stall:** assert `rst` asynchronously during a stall. All outputs take their reset values immediately, before the next clock edge.
